// File: rtl/led_pkg.sv
// Shared types and constants for the LED matrix scan driver.
package led_pkg;

  localparam int MATRIX_ROWS = 16;
  localparam int MATRIX_COLS = 16;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Level a line rests at when not asserted; XOR against it to apply polarity.
  function automatic logic idle_level(input logic active_high);
    return ~active_high;
  endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// Per-row PWM column gate: passes row data while the dwell count is below the brightness.
module led_pwm_gate
  import led_pkg::*;
#(
  parameter int COLS            = MATRIX_COLS,
  parameter int CW              = 4,
  parameter int BW              = 4,
  parameter int COL_ACTIVE_HIGH = 1
) (
  input  logic            drive_i,
  input  logic [CW-1:0]   dwell_cnt_i,
  input  logic [BW-1:0]   bright_i,
  input  logic [COLS-1:0] row_data_i,
  output logic [COLS-1:0] col_d_o
);

  localparam int W = (CW > BW) ? CW : BW;
  localparam logic [COLS-1:0] COL_IDLE = {COLS{idle_level(COL_ACTIVE_HIGH != 0)}};

  logic lit;

  always_comb begin
    lit     = drive_i && (W'(dwell_cnt_i) < W'(bright_i));
    col_d_o = (lit ? row_data_i : '0) ^ COL_IDLE;
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix scanner with double-buffered frames, blanking and per-row PWM.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int ROWS            = MATRIX_ROWS,
  parameter int COLS            = MATRIX_COLS,
  parameter int BLANK_CYCLES    = 1,
  parameter int DWELL_CYCLES    = 8,
  parameter int BW              = 4,
  parameter int ROW_ACTIVE_HIGH = 1,
  parameter int COL_ACTIVE_HIGH = 1
) (
  input  logic                 led_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] fb_in,
  input  logic                 fb_load,
  input  logic [BW-1:0]        brightness,
  output logic                 fb_ack,
  output logic                 frame_start,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col
);

  localparam int MAXC = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(ROWS);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_ONE    = {{(ROWS-1){1'b0}}, 1'b1};
  localparam logic [ROWS-1:0] ROW_IDLE   = {ROWS{idle_level(ROW_ACTIVE_HIGH != 0)}};
  localparam logic [COLS-1:0] COL_IDLE   = {COLS{idle_level(COL_ACTIVE_HIGH != 0)}};

  scan_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]        row_idx_q, row_idx_d;
  logic [BW-1:0]        bright_q, bright_d;
  logic [ROWS*COLS-1:0] front_q, back_q;
  logic                 pending_q, swapped_q;
  logic                 frame_end, swap;
  logic                 drive, frame_start_d, fb_ack_d;
  logic [ROWS-1:0]      row_d;
  logic [COLS-1:0]      col_d;
  logic [ROWS-1:0]      row_q;
  logic [COLS-1:0]      col_q;
  logic                 fb_ack_q, frame_start_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    bright_d  = bright_q;
    frame_end = 1'b0;
    if (enable) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d  = ST_DRIVE;
            cnt_d    = '0;
            bright_d = brightness;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (row_idx_q == ROW_LAST) begin
              row_idx_d = '0;
              frame_end = 1'b1;
            end else begin
              row_idx_d = row_idx_q + RW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // Outputs trail the scan position by one edge so every pin comes straight from a flop.
  always_comb begin
    swap          = frame_end && pending_q;
    drive         = enable && (state_q == ST_DRIVE);
    frame_start_d = enable && (state_q == ST_BLANK) && (cnt_q == '0) && (row_idx_q == '0);
    fb_ack_d      = frame_start_d && swapped_q;
    row_d         = (drive ? (ROW_ONE << row_idx_q) : '0) ^ ROW_IDLE;
  end

  led_pwm_gate #(
    .COLS            (COLS),
    .CW              (CW),
    .BW              (BW),
    .COL_ACTIVE_HIGH (COL_ACTIVE_HIGH)
  ) u_pwm_gate (
    .drive_i     (drive),
    .dwell_cnt_i (cnt_q),
    .bright_i    (bright_q),
    .row_data_i  (front_q[row_idx_q*COLS +: COLS]),
    .col_d_o     (col_d)
  );

  always_ff @(posedge led_clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      row_idx_q     <= '0;
      bright_q      <= '0;
      front_q       <= '0;
      back_q        <= '0;
      pending_q     <= 1'b0;
      swapped_q     <= 1'b0;
      row_q         <= ROW_IDLE;
      col_q         <= COL_IDLE;
      fb_ack_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_idx_q     <= row_idx_d;
      bright_q      <= bright_d;
      row_q         <= row_d;
      col_q         <= col_d;
      fb_ack_q      <= fb_ack_d;
      frame_start_q <= frame_start_d;
      if (fb_load) back_q <= fb_in;
      // A load on the swap edge lands after the promotion and stays pending.
      if (swap) begin
        front_q   <= back_q;
        pending_q <= fb_load;
      end else if (fb_load) begin
        pending_q <= 1'b1;
      end
      if (swap) swapped_q <= 1'b1;
      else if (frame_start_d) swapped_q <= 1'b0;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign fb_ack      = fb_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner against a frame-position reference model.
module tb_led_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int BLANK = 1;
  localparam int DWELL = 4;
  localparam int BW    = 3;
  localparam int SLOT  = BLANK + DWELL;
  localparam int P     = ROWS * SLOT;

  typedef struct packed {
    logic            ack;
    logic            fs;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
  } exp_t;

  logic                 led_clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic [ROWS*COLS-1:0] fb_in = '0;
  logic                 fb_load = 1'b0;
  logic [BW-1:0]        brightness = '0;
  logic                 fb_ack, frame_start;
  logic [ROWS-1:0]      row;
  logic [COLS-1:0]      col;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  exp_t expq[$];
  exp_t mon_e;
  exp_t got;

  // Reference model: scan position within the frame plus buffer contents.
  int                   pos;
  int                   m_blat;
  logic [ROWS*COLS-1:0] m_front, m_back;
  bit                   m_pend, m_ack_due;

  always #5 led_clk = ~led_clk;

  led_matrix_scanner #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .BLANK_CYCLES    (BLANK),
    .DWELL_CYCLES    (DWELL),
    .BW              (BW),
    .ROW_ACTIVE_HIGH (1),
    .COL_ACTIVE_HIGH (1)
  ) dut (
    .led_clk     (led_clk),
    .rst         (rst),
    .enable      (enable),
    .fb_in       (fb_in),
    .fb_load     (fb_load),
    .brightness  (brightness),
    .fb_ack      (fb_ack),
    .frame_start (frame_start),
    .row         (row),
    .col         (col)
  );

  always @(negedge led_clk) begin
    cyc <= cyc + 1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      got   = {fb_ack, frame_start, row, col};
      compared++;
      if (got !== mon_e) begin
        mismatched++;
        $display("FAIL scan cyc=%0d: got ack=%b fs=%b row=%b col=%b, want ack=%b fs=%b row=%b col=%b",
                 cyc, fb_ack, frame_start, row, col, mon_e.ack, mon_e.fs, mon_e.row, mon_e.col);
      end
    end
  end

  task automatic step(input bit r, input bit en, input bit ld,
                      input logic [ROWS*COLS-1:0] d, input logic [BW-1:0] br);
    exp_t e;
    int   slot, rr;
    @(negedge led_clk);
    #1;
    rst = r; enable = en; fb_load = ld; fb_in = d; brightness = br;
    e = '0;
    if (r) begin
      pos = 0; m_blat = 0; m_front = '0; m_back = '0; m_pend = 0; m_ack_due = 0;
    end else begin
      if (en) begin
        slot = pos % SLOT;
        rr   = pos / SLOT;
        if (slot < BLANK) begin
          e.fs  = (pos == 0);
          e.ack = (pos == 0) && m_ack_due;
          if (pos == 0) m_ack_due = 0;
        end else begin
          e.row = ROWS'(1 << rr);
          if (slot - BLANK < m_blat) e.col = m_front[rr*COLS +: COLS];
        end
        if (slot == BLANK - 1) m_blat = int'(br);
        if (pos == P - 1 && m_pend) begin
          m_front = m_back; m_pend = 0; m_ack_due = 1;
        end
        pos = (pos + 1) % P;
      end
      if (ld) begin
        m_back = d; m_pend = 1;
      end
    end
    expq.push_back(e);
  endtask

  task automatic run(input int n, input logic [BW-1:0] br);
    for (int i = 0; i < n; i++) step(0, 1, 0, '0, br);
  endtask

  // Advance until the model sits at scan position tgt (bounded).
  task automatic run_to(input int tgt, input logic [BW-1:0] br);
    int guard = 0;
    while (pos != tgt && guard < 4 * P) begin
      step(0, 1, 0, '0, br);
      guard++;
    end
    compared++;
    if (pos != tgt) begin
      mismatched++;
      $display("FAIL run_to: reached pos %0d, required %0d", pos, tgt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a load that must be ignored, then two dark frames.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 16'h8421, 3'd4);
    run(2 * P, 3'd4);

    // Diagonal pattern at full dwell.
    step(0, 1, 1, 16'h8421, 3'd4);
    run_to(0, 3'd4);
    run(2 * P, 3'd4);

    // Brightness sweep on an all-lit frame.
    step(0, 1, 1, 16'hFFFF, 3'd1);
    run_to(0, 3'd1);
    run(P, 3'd1);
    run(P, 3'd0);
    run(P, 3'd7);

    // Last-wins loads, then a load exactly on the swap edge.
    run(3, 3'd4);
    step(0, 1, 1, 16'h000F, 3'd4);
    run(2, 3'd4);
    step(0, 1, 1, 16'h00F0, 3'd4);
    run_to(P - 1, 3'd4);
    step(0, 1, 1, 16'h0F00, 3'd4);
    run(2 * P, 3'd4);

    // Enable drop in the middle of row 2 drive.
    run_to(2 * SLOT + BLANK + 1, 3'd4);
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0, 3'd4);
    run(P, 3'd4);

    // Reset in row 3 drive with a simultaneous load pending.
    step(0, 1, 1, 16'h1234, 3'd4);
    run_to(3 * SLOT + BLANK + 2, 3'd4);
    step(1, 1, 1, 16'hABCD, 3'd4);
    run(2 * P, 3'd4);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 14) == 0, ROWS*COLS'($urandom), BW'($urandom_range(0, 7)));
    end

    @(negedge led_clk);
    #1;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
